// File: rtl/icache_refill_ctrl.sv
// I-cache line refill sequencer: miss capture, block read, beat assembly, one-cycle array write.
// Optional early-fetch beat bypass outputs are enabled with ICACHE_REFILL_BYPASS_EN.
module icache_refill_ctrl #(
   parameter int unsigned NUM_WAYS            = 4,
   parameter int unsigned NUM_BANKS           = 4,
   parameter int unsigned SETS_PER_BANK_WIDTH = 8,
   parameter int unsigned BLOCK_WIDTH         = 512,
   parameter int unsigned MEM_DATA_WIDTH      = 64,
   parameter int unsigned ADDR_WIDTH          = 32
) (
   input  logic                                         clk_i,
   input  logic                                         rst_ni,
   input  logic                                         miss_valid_i,
   output logic                                         miss_ready_o,
   input  logic [ADDR_WIDTH-1:0]                        miss_addr_i,
   input  logic [NUM_WAYS-1:0]                          miss_way_i,
   output logic                                         mem_req_valid_o,
   input  logic                                         mem_req_ready_i,
   output logic [ADDR_WIDTH-1:0]                        mem_req_addr_o,
   input  logic                                         mem_rsp_valid_i,
   input  logic [MEM_DATA_WIDTH-1:0]                    mem_rsp_data_i,
   output logic [SETS_PER_BANK_WIDTH-1:0]               w_bank_addr_o,
   output logic [$clog2(NUM_BANKS)-1:0]                 w_bank_sel_o,
   output logic [NUM_WAYS-1:0]                          we_way_mask_o,
   output logic [BLOCK_WIDTH-1:0]                       wdata_o,
   output logic                                         refill_done_o,
   output logic                                         busy_o
`ifdef ICACHE_REFILL_BYPASS_EN
   ,
   output logic                                         bypass_valid_o,
   output logic [$clog2(BLOCK_WIDTH/MEM_DATA_WIDTH)-1:0] bypass_beat_o,
   output logic [MEM_DATA_WIDTH-1:0]                    bypass_data_o
`endif
);

   localparam int unsigned OFF    = $clog2(BLOCK_WIDTH / 8);
   localparam int unsigned BEATS  = BLOCK_WIDTH / MEM_DATA_WIDTH;
   localparam int unsigned BANK_W = $clog2(NUM_BANKS);
   localparam int unsigned CNT_W  = $clog2(BEATS) + 1;

   typedef enum logic [1:0] {StIdle, StReq, StRecv, StWrite} state_e;

   state_e                  state_q;
   logic [ADDR_WIDTH-1:OFF] addr_q;
   logic [NUM_WAYS-1:0]     way_q;
   logic [CNT_W-1:0]        cnt_q;
   logic [BLOCK_WIDTH-1:0]  buf_q;

   // Byte offset is never needed: requests are always block aligned.
   logic unused_offset;
   assign unused_offset = ^miss_addr_i[OFF-1:0];

   assign mem_req_addr_o = {addr_q, {OFF{1'b0}}};
   assign w_bank_sel_o   = addr_q[OFF+BANK_W-1:OFF];
   assign w_bank_addr_o  = addr_q[OFF+BANK_W+SETS_PER_BANK_WIDTH-1:OFF+BANK_W];
   assign wdata_o        = buf_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q         <= StIdle;
         addr_q          <= '0;
         way_q           <= '0;
         cnt_q           <= '0;
         buf_q           <= '0;
         miss_ready_o    <= 1'b1;
         mem_req_valid_o <= 1'b0;
         we_way_mask_o   <= '0;
         refill_done_o   <= 1'b0;
         busy_o          <= 1'b0;
`ifdef ICACHE_REFILL_BYPASS_EN
         bypass_valid_o  <= 1'b0;
         bypass_beat_o   <= '0;
         bypass_data_o   <= '0;
`endif
      end else begin
`ifdef ICACHE_REFILL_BYPASS_EN
         bypass_valid_o <= 1'b0;
`endif
         unique case (state_q)
            StIdle: begin
               if (miss_valid_i) begin
                  addr_q          <= miss_addr_i[ADDR_WIDTH-1:OFF];
                  way_q           <= miss_way_i;
                  state_q         <= StReq;
                  miss_ready_o    <= 1'b0;
                  mem_req_valid_o <= 1'b1;
                  busy_o          <= 1'b1;
               end
            end
            StReq: begin
               if (mem_req_ready_i) begin
                  cnt_q           <= '0;
                  state_q         <= StRecv;
                  mem_req_valid_o <= 1'b0;
               end
            end
            StRecv: begin
               if (mem_rsp_valid_i) begin
                  for (int b = 0; b < int'(BEATS); b++) begin
                     if (cnt_q == CNT_W'(b)) begin
                        buf_q[b*MEM_DATA_WIDTH +: MEM_DATA_WIDTH] <= mem_rsp_data_i;
                     end
                  end
                  cnt_q <= cnt_q + CNT_W'(1);
`ifdef ICACHE_REFILL_BYPASS_EN
                  bypass_valid_o <= 1'b1;
                  bypass_beat_o  <= cnt_q[CNT_W-2:0];
                  bypass_data_o  <= mem_rsp_data_i;
`endif
                  if (cnt_q == CNT_W'(BEATS - 1)) begin
                     state_q       <= StWrite;
                     we_way_mask_o <= way_q;
                     refill_done_o <= 1'b1;
                  end
               end
            end
            StWrite: begin
               state_q       <= StIdle;
               we_way_mask_o <= '0;
               refill_done_o <= 1'b0;
               busy_o        <= 1'b0;
               miss_ready_o  <= 1'b1;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Self-checking bench for icache_refill_ctrl (default parameters).
// Define ICACHE_REFILL_BYPASS_EN to also exercise the bypass outputs.
module tb_icache_refill_ctrl;

   localparam int unsigned BEATS = 8;

   logic         clk_i = 1'b0;
   logic         rst_ni = 1'b0;
   logic         miss_valid_i = 1'b0;
   logic         miss_ready_o;
   logic [31:0]  miss_addr_i = '0;
   logic [3:0]   miss_way_i = '0;
   logic         mem_req_valid_o;
   logic         mem_req_ready_i = 1'b0;
   logic [31:0]  mem_req_addr_o;
   logic         mem_rsp_valid_i = 1'b0;
   logic [63:0]  mem_rsp_data_i = '0;
   logic [7:0]   w_bank_addr_o;
   logic [1:0]   w_bank_sel_o;
   logic [3:0]   we_way_mask_o;
   logic [511:0] wdata_o;
   logic         refill_done_o;
   logic         busy_o;
`ifdef ICACHE_REFILL_BYPASS_EN
   logic         bypass_valid_o;
   logic [2:0]   bypass_beat_o;
   logic [63:0]  bypass_data_o;
   logic [66:0]  byp_q[$];
`endif

   icache_refill_ctrl dut (
      .clk_i           (clk_i),
      .rst_ni          (rst_ni),
      .miss_valid_i    (miss_valid_i),
      .miss_ready_o    (miss_ready_o),
      .miss_addr_i     (miss_addr_i),
      .miss_way_i      (miss_way_i),
      .mem_req_valid_o (mem_req_valid_o),
      .mem_req_ready_i (mem_req_ready_i),
      .mem_req_addr_o  (mem_req_addr_o),
      .mem_rsp_valid_i (mem_rsp_valid_i),
      .mem_rsp_data_i  (mem_rsp_data_i),
      .w_bank_addr_o   (w_bank_addr_o),
      .w_bank_sel_o    (w_bank_sel_o),
      .we_way_mask_o   (we_way_mask_o),
      .wdata_o         (wdata_o),
      .refill_done_o   (refill_done_o),
      .busy_o          (busy_o)
`ifdef ICACHE_REFILL_BYPASS_EN
      ,
      .bypass_valid_o  (bypass_valid_o),
      .bypass_beat_o   (bypass_beat_o),
      .bypass_data_o   (bypass_data_o)
`endif
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [31:0]  req_addr;
      logic [7:0]   idx;
      logic [1:0]   bank;
      logic [3:0]   way;
      logic [511:0] data;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   done_cnt = 0;

   always @(posedge clk_i) cyc <= cyc + 1;
   always @(negedge clk_i) if (refill_done_o) done_cnt <= done_cnt + 1;
`ifdef ICACHE_REFILL_BYPASS_EN
   always @(negedge clk_i) if (bypass_valid_o) byp_q.push_back({bypass_beat_o, bypass_data_o});
`endif

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish (time %0t, required < 200000)", $time);
      $fatal(1);
   end

   function automatic logic [511:0] make_block(input logic [31:0] base);
      logic [511:0] blk;
      for (int k = 0; k < int'(BEATS); k++) blk[k*64 +: 64] = {base, 32'(k)};
      return blk;
   endfunction

   // Holds miss_valid until the handshake edge; hs_cyc is cyc just after that edge.
   task automatic send_miss(input logic [31:0] a, input logic [3:0] w,
                            output int hs_cyc, output bit ok);
      ok = 1'b0;
      miss_valid_i = 1'b1;
      miss_addr_i  = a;
      miss_way_i   = w;
      for (int n = 0; n < 200 && !ok; n++) begin
         if (miss_ready_o) ok = 1'b1;
         @(posedge clk_i); #1;
      end
      hs_cyc = cyc;
      miss_valid_i = 1'b0;
   endtask

   task automatic accept_req(input int stall, input bit spur, output logic [31:0] addr_seen,
                             output bit stable, output bit ok);
      ok = 1'b0;
      stable = 1'b1;
      for (int n = 0; n < 200; n++) begin
         if (mem_req_valid_o) begin
            ok = 1'b1;
            break;
         end
         @(posedge clk_i); #1;
      end
      addr_seen = mem_req_addr_o;
      for (int s = 0; s < stall; s++) begin
         mem_rsp_valid_i = spur;
         mem_rsp_data_i  = 64'hDEAD_BEEF_DEAD_BEEF;
         @(posedge clk_i); #1;
         if (!mem_req_valid_o || mem_req_addr_o !== addr_seen) stable = 1'b0;
      end
      mem_rsp_valid_i = 1'b0;
      mem_req_ready_i = 1'b1;
      @(posedge clk_i); #1;
      mem_req_ready_i = 1'b0;
   endtask

   task automatic send_beats(input logic [511:0] blk, input int gap, input int nbeats);
      for (int k = 0; k < nbeats; k++) begin
         mem_rsp_valid_i = 1'b1;
         mem_rsp_data_i  = blk[k*64 +: 64];
         @(posedge clk_i); #1;
         mem_rsp_valid_i = 1'b0;
         if (k < nbeats - 1) repeat (gap) begin @(posedge clk_i); #1; end
      end
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk_i);
      #1;
      checks++;
      if ({miss_ready_o, busy_o, mem_req_valid_o, we_way_mask_o, refill_done_o} !== 8'b1000_0000) begin
         errors++;
         $display("FAIL reset_ctrl: ready/busy/reqv/we/done=%b required 10000000",
                  {miss_ready_o, busy_o, mem_req_valid_o, we_way_mask_o, refill_done_o});
      end
      checks++;
      if (mem_req_addr_o !== 32'h0 || w_bank_addr_o !== 8'h0 || w_bank_sel_o !== 2'h0) begin
         errors++;
         $display("FAIL reset_addr: req=%h idx=%h bank=%h required all 0",
                  mem_req_addr_o, w_bank_addr_o, w_bank_sel_o);
      end
      checks++;
      if (wdata_o !== 512'h0) begin
         errors++;
         $display("FAIL reset_wdata: got %h required 0", wdata_o);
      end
      @(negedge clk_i);
      rst_ni = 1'b1;
      @(posedge clk_i); #1;
   endtask

   task automatic test_basic();
      exp_t e;
      int h, lat;
      bit ok, st;
      logic [31:0] a;
      e = '{32'h0000_1A40, 8'h1A, 2'd1, 4'b0100, make_block(32'h0)};
      sb.push_back(e);
      send_miss(32'h0000_1A40, 4'b0100, h, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL basic_accept: miss never accepted, required accept"); end
      accept_req(0, 1'b0, a, st, ok);
      checks++;
      if (!ok || a !== e.req_addr) begin
         errors++;
         $display("FAIL basic_req_addr: got %h (valid seen %0d) required %h", a, ok, e.req_addr);
      end
      send_beats(e.data, 0, 8);
      // h is cycle 1 of the refill, so the write cycle number is cyc - h + 1.
      lat = cyc - h + 1;
      checks++;
      if (refill_done_o !== 1'b1 || lat != BEATS + 2) begin
         errors++;
         $display("FAIL basic_latency: done=%b at cycle %0d required 1 at cycle %0d",
                  refill_done_o, lat, BEATS + 2);
      end
      e = sb.pop_front();
      checks++;
      if (we_way_mask_o !== e.way || w_bank_addr_o !== e.idx || w_bank_sel_o !== e.bank) begin
         errors++;
         $display("FAIL basic_write: way=%b idx=%h bank=%0d required way=%b idx=%h bank=%0d",
                  we_way_mask_o, w_bank_addr_o, w_bank_sel_o, e.way, e.idx, e.bank);
      end
      checks++;
      if (wdata_o !== e.data) begin
         errors++;
         $display("FAIL basic_wdata: got %h required %h", wdata_o, e.data);
      end
      @(posedge clk_i); #1;
      checks++;
      if (refill_done_o !== 1'b0 || we_way_mask_o !== 4'b0 || miss_ready_o !== 1'b1 ||
          busy_o !== 1'b0) begin
         errors++;
         $display("FAIL basic_one_cycle: done=%b we=%b ready=%b busy=%b required 0 0000 1 0",
                  refill_done_o, we_way_mask_o, miss_ready_o, busy_o);
      end
   endtask

   task automatic test_unaligned_stall();
      exp_t e;
      int h;
      bit ok, st;
      logic [31:0] a;
      e = '{32'h0000_FF40, 8'hFF, 2'd1, 4'b0001, make_block(32'hA5A5_0000)};
      sb.push_back(e);
      send_miss(32'h0000_FF7C, 4'b0001, h, ok);
      accept_req(5, 1'b0, a, st, ok);
      checks++;
      if (!ok || !st || a !== e.req_addr) begin
         errors++;
         $display("FAIL stall_req: addr=%h stable=%0d required %h stable=1", a, st, e.req_addr);
      end
      checks++;
      if (w_bank_sel_o !== e.bank || w_bank_addr_o !== e.idx) begin
         errors++;
         $display("FAIL stall_bank_idx: bank=%0d idx=%h required bank=%0d idx=%h",
                  w_bank_sel_o, w_bank_addr_o, e.bank, e.idx);
      end
      send_beats(e.data, 0, 8);
      e = sb.pop_front();
      checks++;
      if (refill_done_o !== 1'b1 || we_way_mask_o !== e.way || wdata_o !== e.data) begin
         errors++;
         $display("FAIL stall_write: done=%b way=%b data=%h required 1 %b %h",
                  refill_done_o, we_way_mask_o, wdata_o, e.way, e.data);
      end
      @(posedge clk_i); #1;
   endtask

   task automatic test_gapped();
      exp_t e;
      int h;
      bit ok, st;
      logic [31:0] a;
      logic [511:0] prev;
      prev = wdata_o;
      mem_rsp_valid_i = 1'b1;
      mem_rsp_data_i  = 64'hBAD0_BAD0_BAD0_BAD0;
      repeat (2) begin @(posedge clk_i); #1; end
      mem_rsp_valid_i = 1'b0;
      checks++;
      if (wdata_o !== prev || busy_o !== 1'b0) begin
         errors++;
         $display("FAIL idle_spurious: wdata=%h busy=%b required %h 0", wdata_o, busy_o, prev);
      end
      e = '{32'h0003_2180, 8'h21, 2'd2, 4'b1000, make_block(32'h5EED_0000)};
      sb.push_back(e);
      send_miss(32'h0003_2184, 4'b1000, h, ok);
      accept_req(2, 1'b1, a, st, ok);
      send_beats(e.data, 1, 8);
      e = sb.pop_front();
      checks++;
      if (refill_done_o !== 1'b1 || we_way_mask_o !== e.way) begin
         errors++;
         $display("FAIL gapped_done: done=%b way=%b required 1 %b", refill_done_o, we_way_mask_o,
                  e.way);
      end
      checks++;
      if (wdata_o !== e.data) begin
         errors++;
         $display("FAIL gapped_wdata: got %h required %h", wdata_o, e.data);
      end
      @(posedge clk_i); #1;
   endtask

   task automatic test_back_to_back();
      exp_t e;
      int h;
      bit ok, st, held;
      logic [31:0] a;
      e = '{32'h0000_0440, 8'h04, 2'd1, 4'b0010, make_block(32'h1111_0000)};
      sb.push_back(e);
      sb.push_back('{32'h0000_ABC0, 8'hAB, 2'd3, 4'b0100, make_block(32'h2222_0000)});
      send_miss(32'h0000_0440, 4'b0010, h, ok);
      miss_valid_i = 1'b1;
      miss_addr_i  = 32'h0000_ABC8;
      miss_way_i   = 4'b0100;
      held = (miss_ready_o === 1'b0);
      accept_req(0, 1'b0, a, st, ok);
      held = held && (miss_ready_o === 1'b0);
      send_beats(e.data, 0, 8);
      e = sb.pop_front();
      checks++;
      if (!held || miss_ready_o !== 1'b0 || refill_done_o !== 1'b1 || wdata_o !== e.data) begin
         errors++;
         $display("FAIL b2b_first: held=%0d ready=%b done=%b required held=1 ready=0 done=1",
                  held, miss_ready_o, refill_done_o);
      end
      @(posedge clk_i); #1;
      checks++;
      if (miss_ready_o !== 1'b1) begin
         errors++;
         $display("FAIL b2b_ready_u2: ready=%b required 1", miss_ready_o);
      end
      @(posedge clk_i); #1;
      miss_valid_i = 1'b0;
      e = sb.pop_front();
      checks++;
      if (mem_req_valid_o !== 1'b1 || mem_req_addr_o !== e.req_addr) begin
         errors++;
         $display("FAIL b2b_second_req: valid=%b addr=%h required 1 %h", mem_req_valid_o,
                  mem_req_addr_o, e.req_addr);
      end
      accept_req(0, 1'b0, a, st, ok);
      send_beats(e.data, 0, 8);
      checks++;
      if (refill_done_o !== 1'b1 || we_way_mask_o !== e.way || wdata_o !== e.data ||
          w_bank_addr_o !== e.idx || w_bank_sel_o !== e.bank) begin
         errors++;
         $display("FAIL b2b_second_write: done=%b way=%b idx=%h bank=%0d required 1 %b %h %0d",
                  refill_done_o, we_way_mask_o, w_bank_addr_o, w_bank_sel_o, e.way, e.idx, e.bank);
      end
      @(posedge clk_i); #1;
   endtask

   task automatic test_reset_mid();
      exp_t e;
      int h, d0;
      bit ok, st;
      logic [31:0] a;
      logic [511:0] blk;
      blk = make_block(32'h7777_0000);
      send_miss(32'h0000_3300, 4'b0001, h, ok);
      accept_req(0, 1'b0, a, st, ok);
      send_beats(blk, 0, 4);
      mem_rsp_valid_i = 1'b1;
      mem_rsp_data_i  = blk[4*64 +: 64];
      #2;
      rst_ni = 1'b0;
      mem_rsp_valid_i = 1'b0;
      #1;
      d0 = done_cnt;
      checks++;
      if ({miss_ready_o, busy_o, mem_req_valid_o, we_way_mask_o, refill_done_o} !== 8'b1000_0000 ||
          mem_req_addr_o !== 32'h0 || w_bank_addr_o !== 8'h0 || w_bank_sel_o !== 2'h0) begin
         errors++;
         $display("FAIL midreset_outputs: ctrl=%b req=%h idx=%h bank=%h required 10000000 0 0 0",
                  {miss_ready_o, busy_o, mem_req_valid_o, we_way_mask_o, refill_done_o},
                  mem_req_addr_o, w_bank_addr_o, w_bank_sel_o);
      end
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      rst_ni = 1'b1;
      repeat (12) begin @(posedge clk_i); #1; end
      checks++;
      if (done_cnt != d0 || busy_o !== 1'b0) begin
         errors++;
         $display("FAIL midreset_no_write: done pulses=%0d busy=%b required 0 0", done_cnt - d0,
                  busy_o);
      end
      e = '{32'h0000_5540, 8'h55, 2'd1, 4'b0010, make_block(32'h8888_0000)};
      sb.push_back(e);
      send_miss(32'h0000_5540, 4'b0010, h, ok);
      accept_req(1, 1'b0, a, st, ok);
      send_beats(e.data, 0, 8);
      e = sb.pop_front();
      checks++;
      if (refill_done_o !== 1'b1 || we_way_mask_o !== e.way || wdata_o !== e.data) begin
         errors++;
         $display("FAIL midreset_followup: done=%b way=%b data=%h required 1 %b %h",
                  refill_done_o, we_way_mask_o, wdata_o, e.way, e.data);
      end
      @(posedge clk_i); #1;
   endtask

   task automatic test_zero_way();
      exp_t e;
      int h, d0;
      bit ok, st;
      logic [31:0] a;
      e = '{32'h0000_2000, 8'h20, 2'd0, 4'b0000, make_block(32'h0)};
      sb.push_back(e);
`ifdef ICACHE_REFILL_BYPASS_EN
      byp_q.delete();
`endif
      d0 = done_cnt;
      send_miss(32'h0000_2000, 4'b0000, h, ok);
      accept_req(0, 1'b0, a, st, ok);
      send_beats(e.data, 0, 8);
      e = sb.pop_front();
      checks++;
      if (refill_done_o !== 1'b1 || we_way_mask_o !== e.way || wdata_o !== e.data) begin
         errors++;
         $display("FAIL zero_way_write: done=%b way=%b required 1 0000", refill_done_o,
                  we_way_mask_o);
      end
      @(posedge clk_i); #1;
      checks++;
      if (done_cnt != d0 + 1) begin
         errors++;
         $display("FAIL zero_way_pulses: done pulses=%0d required 1", done_cnt - d0);
      end
`ifdef ICACHE_REFILL_BYPASS_EN
      checks++;
      if (byp_q.size() != BEATS || bypass_valid_o !== 1'b0) begin
         errors++;
         $display("FAIL bypass_count: pulses=%0d valid_in_idle=%b required %0d 0", byp_q.size(),
                  bypass_valid_o, BEATS);
      end
      for (int k = 0; k < byp_q.size(); k++) begin
         checks++;
         if (byp_q[k] !== {3'(k), e.data[k*64 +: 64]}) begin
            errors++;
            $display("FAIL bypass_beat%0d: got %h required %h", k, byp_q[k],
                     {3'(k), e.data[k*64 +: 64]});
         end
      end
`endif
   endtask

   initial begin
      test_reset();
      test_basic();
      test_unaligned_stall();
      test_gapped();
      test_back_to_back();
      test_reset_mid();
      test_zero_way();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d entries left required 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
